// File: rtl/cordic_pkg.sv
// Shared constants and helpers for the CORDIC sharing arbiter.
package cordic_pkg;

  localparam int CORDIC_ANGW = 34;

  // Gain-compensated X input: (2^(w-1))/1.647 - w, computed in integer math (truncating).
  function automatic int an_gain(input int w);
    return int'(((longint'(1) << (w - 1)) * 1000) / 1647) - w;
  endfunction

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cordic_arbiter_rr.sv
// Round-robin picker: first eligible requester after the last grant, circularly.
module rr_arbiter
  import cordic_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] eligible,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any
);

  logic [IDW-1:0] ptr;
  logic           found;
  int             j;

  assign grant_any = |eligible;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && eligible[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDW'(j);
      end
    end
  end

  // Reset pointer to the last requester so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= IDW'(NREQ - 1);
    end else if (grant_any) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one pipelined CORDIC core among NREQ requesters; results return
// to the issuing requester a fixed LAT+1 cycles after its grant.
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ANGW  = CORDIC_ANGW,
  parameter int NREQ  = 4,
  parameter int LAT   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         en_mask,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*ANGW-1:0]    angle_in,
  output logic [NREQ-1:0]         ack,
  output logic [WIDTH-1:0]        core_x,
  output logic [WIDTH-1:0]        core_y,
  output logic [ANGW-1:0]         core_angle,
  input  logic [WIDTH-1:0]        core_cos,
  input  logic [WIDTH-1:0]        core_sin,
  output logic [NREQ-1:0]         res_valid,
  output logic [WIDTH-1:0]        res_cos,
  output logic [WIDTH-1:0]        res_sin,
  output logic [$clog2(LAT+2)-1:0] inflight
);

  localparam int IDW = id_width(NREQ);
  localparam int IFW = $clog2(LAT + 2);

  // Handshake: a requester holds req and its angle stable until it sees ack
  // high for one cycle; that ack means the angle was captured on the edge
  // that raised it. Dropping req before ack withdraws the request.

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;

  // Stage 0 lines up with core_angle; stage LAT lines up with valid core outputs.
  logic [LAT:0]    tag_v;
  logic [IDW-1:0]  tag_id [0:LAT];
  logic            ret;

  assign eligible = req & en_mask;
  assign core_x   = WIDTH'(an_gain(WIDTH));
  assign core_y   = '0;
  assign ret      = tag_v[LAT];

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .eligible  (eligible),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack        <= '0;
      core_angle <= '0;
      tag_v      <= '0;
      for (int s = 0; s <= LAT; s++) tag_id[s] <= '0;
      res_valid  <= '0;
      res_cos    <= '0;
      res_sin    <= '0;
      inflight   <= '0;
    end else begin
      ack <= grant;
      if (grant_any) core_angle <= angle_in[int'(grant_idx)*ANGW +: ANGW];

      tag_v     <= {tag_v[LAT-1:0], grant_any};
      tag_id[0] <= grant_idx;
      for (int s = 1; s <= LAT; s++) tag_id[s] <= tag_id[s-1];

      res_valid <= ret ? (NREQ'(1) << tag_id[LAT]) : '0;
      if (ret) begin
        res_cos <= core_cos;
        res_sin <= core_sin;
      end

      case ({grant_any, ret})
        2'b10:   inflight <= inflight + IFW'(1);
        2'b01:   inflight <= inflight - IFW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with the core modeled as a LAT-cycle delay
// of the angle: cos = angle[7:0], sin = angle[15:8].
module tb_cordic_arbiter;

  localparam int WIDTH = 8;
  localparam int ANGW  = 34;
  localparam int NREQ  = 4;
  localparam int LAT   = 8;
  localparam int IFW   = $clog2(LAT + 2);
  localparam int EW    = 36;   // {due[15:0], onehot[3:0], cos[7:0], sin[7:0]}
  localparam logic [WIDTH-1:0] AN_EXP = 8'd69;  // 128000/1647 = 77, minus 8

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       en_mask;
  logic [NREQ-1:0]       req;
  logic [NREQ*ANGW-1:0]  angle_in;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      core_x;
  logic [WIDTH-1:0]      core_y;
  logic [ANGW-1:0]       core_angle;
  logic [WIDTH-1:0]      core_cos;
  logic [WIDTH-1:0]      core_sin;
  logic [NREQ-1:0]       res_valid;
  logic [WIDTH-1:0]      res_cos;
  logic [WIDTH-1:0]      res_sin;
  logic [IFW-1:0]        inflight;

  cordic_arbiter #(
    .WIDTH (WIDTH),
    .ANGW  (ANGW),
    .NREQ  (NREQ),
    .LAT   (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_mask    (en_mask),
    .req        (req),
    .angle_in   (angle_in),
    .ack        (ack),
    .core_x     (core_x),
    .core_y     (core_y),
    .core_angle (core_angle),
    .core_cos   (core_cos),
    .core_sin   (core_sin),
    .res_valid  (res_valid),
    .res_cos    (res_cos),
    .res_sin    (res_sin),
    .inflight   (inflight)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: angle registered by the DUT appears on cos/sin LAT cycles later.
  logic [15:0] core_d [0:LAT-1] = '{default: '0};
  always @(posedge clk) begin
    core_d[0] <= core_angle[15:0];
    for (int i = 1; i < LAT; i++) core_d[i] <= core_d[i-1];
  end
  assign core_cos = core_d[LAT-1][7:0];
  assign core_sin = core_d[LAT-1][15:8];

  // Scoreboard state
  logic [EW-1:0]   exp_q [$];
  logic [ANGW-1:0] ang [NREQ];
  logic [ANGW-1:0] exp_angle;
  logic [WIDTH-1:0] last_cos, last_sin;
  int total, bad, cyc, peak;

  typedef struct {
    logic            r;
    logic [NREQ-1:0] rq;
    logic [NREQ-1:0] en;
    logic [NREQ-1:0] eack;
  } vec_t;
  vec_t vecs [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] en,
                              input logic [3:0] eack, input int n);
    vec_t v;
    v.r = r; v.rq = rq; v.en = en; v.eack = eack;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  // Driver + checker for one clock: drive at negedge, check at the next negedge.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] en,
                      input logic [3:0] eack);
    int w;
    logic [EW-1:0] e;
    logic [NREQ-1:0] exp_rv;
    rst     = r;
    req     = rq;
    en_mask = en;
    for (int i = 0; i < NREQ; i++) angle_in[i*ANGW +: ANGW] = ang[i];
    w = -1;
    for (int i = 0; i < NREQ; i++) if (eack[i]) w = i;
    if (!r) begin
      exp_q.delete();
      exp_angle = '0;
      last_cos  = '0;
      last_sin  = '0;
    end else if (w >= 0) begin
      exp_angle = ang[w];
      exp_q.push_back({16'(cyc + LAT + 2), eack, ang[w][7:0], ang[w][15:8]});
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("ack", 64'(ack), 64'(eack));
    chk("core_angle", 64'(core_angle), 64'(exp_angle));
    exp_rv = '0;
    if (exp_q.size() > 0 && exp_q[0][35:20] == 16'(cyc)) begin
      e        = exp_q.pop_front();
      exp_rv   = e[19:16];
      last_cos = e[15:8];
      last_sin = e[7:0];
    end
    chk("res_valid", 64'(res_valid), 64'(exp_rv));
    chk("res_cos", 64'(res_cos), 64'(last_cos));
    chk("res_sin", 64'(res_sin), 64'(last_sin));
    chk("inflight", 64'(inflight), 64'(exp_q.size()));
    if (int'(inflight) > peak) peak = int'(inflight);
    if (r && w >= 0)
      ang[w] = {18'($urandom_range(0, 262143)), ang[w][15:0] + 16'h0111};
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; peak = 0;
    exp_angle = '0; last_cos = '0; last_sin = '0;
    rst = 1'b0; req = '0; en_mask = '0; angle_in = '0;
    for (int i = 0; i < NREQ; i++)
      ang[i] = {18'($urandom_range(0, 262143)), 8'(8'h10 + i), 8'(8'h20 + 3*i)};

    // Reset with all requests high
    add(1'b0, 4'b1111, 4'b1111, 4'b0000, 3);
    // Single request from requester 2, result LAT+1 later
    add(1'b1, 4'b0100, 4'b1111, 4'b0100, 1);
    add(1'b1, 4'b0000, 4'b1111, 4'b0000, 10);
    // Full contention after a fresh reset: strict order 0,1,2,3,0,1,2,3
    add(1'b0, 4'b1111, 4'b1111, 4'b0000, 1);
    add(1'b1, 4'b1111, 4'b1111, 4'b0001, 1);
    add(1'b1, 4'b1111, 4'b1111, 4'b0010, 1);
    add(1'b1, 4'b1111, 4'b1111, 4'b0100, 1);
    add(1'b1, 4'b1111, 4'b1111, 4'b1000, 1);
    add(1'b1, 4'b1111, 4'b1111, 4'b0001, 1);
    add(1'b1, 4'b1111, 4'b1111, 4'b0010, 1);
    add(1'b1, 4'b1111, 4'b1111, 4'b0100, 1);
    add(1'b1, 4'b1111, 4'b1111, 4'b1000, 1);
    add(1'b1, 4'b0000, 4'b1111, 4'b0000, 10);
    // Mask 1010: grants alternate 1,3; inflight saturates at LAT+1
    for (int i = 0; i < 6; i++) begin
      add(1'b1, 4'b1111, 4'b1010, 4'b0010, 1);
      add(1'b1, 4'b1111, 4'b1010, 4'b1000, 1);
    end
    // Enables cleared while results are still in flight
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 10);

    foreach (vecs[i]) step(vecs[i].r, vecs[i].rq, vecs[i].en, vecs[i].eack);

    chk("inflight_peak", 64'(peak), 64'(LAT + 1));
    chk("core_x", 64'(core_x), 64'(AN_EXP));
    chk("core_y", 64'(core_y), 64'd0);

    // Reset mid-flight: three issues discarded, then requester 0 wins first
    step(1'b1, 4'b1111, 4'b1111, 4'b0001);
    step(1'b1, 4'b1111, 4'b1111, 4'b0010);
    step(1'b1, 4'b1111, 4'b1111, 4'b0100);
    step(1'b1, 4'b0000, 4'b1111, 4'b0000);
    step(1'b0, 4'b1111, 4'b1111, 4'b0000);
    for (int i = 0; i < 10; i++) step(1'b1, 4'b0000, 4'b1111, 4'b0000);
    step(1'b1, 4'b1111, 4'b1111, 4'b0001);

    // Requester 3 loses to 1, then withdraws: nothing issued for it
    step(1'b1, 4'b1010, 4'b1111, 4'b0010);
    step(1'b1, 4'b0000, 4'b1111, 4'b0000);
    for (int i = 0; i < 10; i++) step(1'b1, 4'b0000, 4'b1111, 4'b0000);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
